mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
// - Memory-side responder to the processor bus (adrs/rw/dout out, 16-bit din in); holds one 2^AW x DW unified
//   instruction/data store.
// - Serves combinational 16-bit reads and clocked 8-bit writes from the CPU.
// - Contains a byte-stream boot loader (valid/ready) that fills memory while holding the CPU in reset via cpu_clr.
// PARAMETERS
// AW   8   address width; memory depth 2^AW words
// DW   16  word width; instruction fetch width
// BW   8   byte width; CPU store width and loader byte width (DW == 2*BW)
// PORTS
// clk       in   1    single clock, rising edge
// clr       in   1    asynchronous, active-low reset
// cpu_adrs  in   AW   CPU address
// cpu_rw    in   1    1 = read, 0 = write
// cpu_dout  in   BW   CPU write data (accumulator)
// cpu_din   out  DW   read data to CPU
// cpu_clr   out  1    active-low reset driven to the CPU, registered
// ld_start  in   1    start load (sampled in IDLE only)
// ld_base   in   AW   first word address, sampled with ld_start
// ld_words  in   AW+1 number of words to load, sampled with ld_start; valid range 1..2^AW
// ld_valid  in   1    loader byte valid
// ld_data   in   BW   loader byte; within a word, high byte first
// ld_ready  out  1    responder accepts a byte this cycle
// ld_done   out  1    one-cycle pulse at load completion
// BEHAVIOUR
// - Reset (clr=0): state=IDLE, cpu_clr=0, ld_ready=0, ld_done=0, pointer/count/hold regs=0.
//   Memory array is NOT reset and keeps its contents.
// - cpu_clr is 1 in IDLE from the first clk edge after clr deasserts. It is 0 in every other state.
// - Read:
//   - cpu_din = mem[cpu_adrs] combinationally, zero latency, whenever state==IDLE.
//   - cpu_din = 0 in all other states.
// - Write: at a clk edge with state==IDLE, cpu_clr==1 and cpu_rw==0, mem[cpu_adrs][BW-1:0] <= cpu_dout.
//   The upper byte is preserved. A following read of the same address returns the new data.
// - FSM: IDLE -> HI -> LO -> (HI | DONE) -> IDLE
//   - IDLE: if ld_start==1 and ld_words!=0 -> HI; wptr<=ld_base, cnt<=ld_words, cpu_clr<=0.
//     ld_start with ld_words==0 is ignored.
//   - HI: ld_ready=1. On ld_valid: hold<=ld_data, then -> LO.
//   - LO: ld_ready=1. On ld_valid:
//     - mem[wptr] <= {hold, ld_data}; wptr <= wptr+1 (mod 2^AW); cnt <= cnt-1.
//     - If cnt==1 -> DONE, else -> HI.
//   - DONE: ld_done=1 for exactly one cycle, ld_ready=0 -> IDLE. cpu_clr returns to 1 on that edge.
// - Handshake: a byte transfers only when ld_valid & ld_ready at a clk edge. ld_valid may stall for any number of
//   cycles, and state/pointers hold meanwhile.
// - ld_start outside IDLE is ignored. CPU writes during HI/LO/DONE are ignored.
// - Address wrap: a load reaching 2^AW-1 continues at 0. ld_words==2^AW overwrites the whole array exactly once.
// - Reset mid-load: aborts immediately to IDLE. Words already written remain; a partial word in hold is discarded.
// STRUCTURE
// - Shared package (mem_pkg): state enum {IDLE,HI,LO,DONE}, RW_READ=1 / RW_WRITE=0, AW/DW/BW defaults.
// - One sub-module, mem_array: 2^AW x DW, one async read port, one sync write port with per-byte
//   write enables (2 bits).
// - Write-port mux: loader write (full word) in LO, CPU write (low byte) in IDLE. The two are mutually exclusive
//   by FSM state.
// - All FSM, pointer, count and cpu_clr registers: async reset on negedge clr.
// TESTING
// 1. Reset: clr=0 then 1 -> cpu_clr=0 during reset, 1 after the first edge; ld_ready=0, ld_done=0,
//    cpu_din=mem[cpu_adrs].
// 2. Load 3 words at ld_base=8'h10, bytes 12 34 56 78 9A BC with no stalls -> 6 accepted bytes;
//    mem[10]=1234, mem[11]=5678, mem[12]=9ABC; ld_done pulses once; cpu_clr low throughout and high after DONE.
// 3. Wrap and stall: ld_base=8'hFF, ld_words=2, ld_valid toggled every other cycle ->
//    mem[FF] and mem[00] written, no byte lost or duplicated.
// 4. CPU write: mem[20]=ABCD; cpu_rw=0, adrs=20, dout=5A -> mem[20]=AB5A; next-cycle read returns AB5A.
// 5. Ignored requests: ld_words=0 with ld_start -> remains IDLE, cpu_clr stays 1; ld_start during LO -> no effect.
// 6. Reset mid-load: clr=0 after 3 bytes of a 4-word load -> IDLE at once, first word written, second word
//    unchanged, cpu_clr=0 until release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder: loader FSM states,
// CPU read/write encoding and the default geometry of the unified store.
package mem_pkg;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int BW = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_e;
endpackage

// File: rtl/mem_array.sv
// 2^AW x DW storage: one asynchronous read port and one clocked write port
// with a write enable per byte lane. Contents are never reset.
module mem_array #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic [1:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (we[b]) mem[waddr][b*BW +: BW] <= wdata[b*BW +: BW];
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: combinational CPU reads, low-byte CPU writes and a
// byte-stream boot loader that fills memory while holding the CPU in reset.
module mem_responder
  import mem_pkg::*;
#(
  parameter int AW = mem_pkg::AW,
  parameter int DW = mem_pkg::DW,
  parameter int BW = mem_pkg::BW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [AW-1:0] cpu_adrs,
  input  logic          cpu_rw,
  input  logic [BW-1:0] cpu_dout,
  output logic [DW-1:0] cpu_din,
  output logic          cpu_clr,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic [AW:0]   ld_words,
  input  logic          ld_valid,
  input  logic [BW-1:0] ld_data,
  output logic          ld_ready,
  output logic          ld_done
);
  state_e        state_q;
  logic [AW-1:0] wptr_q;
  logic [AW:0]   cnt_q;
  logic [BW-1:0] hold_q;
  logic          cpu_clr_q;
  logic          ld_ready_q;
  logic          ld_done_q;

  logic [1:0]    we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      cpu_clr_q  <= 1'b0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cpu_clr_q <= 1'b1;
          if (ld_start && (ld_words != '0)) begin
            state_q    <= HI;
            wptr_q     <= ld_base;
            cnt_q      <= ld_words;
            cpu_clr_q  <= 1'b0;
            ld_ready_q <= 1'b1;
          end
        end
        HI: begin
          if (ld_valid) begin
            hold_q  <= ld_data;
            state_q <= LO;
          end
        end
        LO: begin
          if (ld_valid) begin
            wptr_q <= wptr_q + AW'(1);
            cnt_q  <= cnt_q - (AW+1)'(1);
            // The last low byte ends the load; ready drops as DONE is entered.
            if (cnt_q == (AW+1)'(1)) begin
              state_q    <= DONE;
              ld_ready_q <= 1'b0;
              ld_done_q  <= 1'b1;
            end else begin
              state_q <= HI;
            end
          end
        end
        DONE: begin
          state_q   <= IDLE;
          ld_done_q <= 1'b0;
          cpu_clr_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Loader and CPU writes are exclusive by state, so a simple priority mux suffices.
  always_comb begin
    we    = 2'b00;
    waddr = cpu_adrs;
    wdata = {{(DW-BW){1'b0}}, cpu_dout};
    if ((state_q == LO) && ld_valid) begin
      we    = 2'b11;
      waddr = wptr_q;
      wdata = {hold_q, ld_data};
    end else if ((state_q == IDLE) && cpu_clr_q && (cpu_rw == RW_WRITE)) begin
      we = 2'b01;
    end
  end

  mem_array #(.AW(AW), .DW(DW), .BW(BW)) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(cpu_adrs),
    .rdata(rdata)
  );

  assign cpu_din  = (state_q == IDLE) ? rdata : '0;
  assign cpu_clr  = cpu_clr_q;
  assign ld_ready = ld_ready_q;
  assign ld_done  = ld_done_q;
endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder against a word-array model of the store.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  cpu_adrs = '0;
  logic        cpu_rw = 1'b1;
  logic [7:0]  cpu_dout = '0;
  logic [15:0] cpu_din;
  logic        cpu_clr;
  logic        ld_start = 1'b0;
  logic [7:0]  ld_base = '0;
  logic [8:0]  ld_words = '0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        ld_ready;
  logic        ld_done;

  mem_responder dut (
    .clk(clk), .clr(clr),
    .cpu_adrs(cpu_adrs), .cpu_rw(cpu_rw), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .cpu_clr(cpu_clr),
    .ld_start(ld_start), .ld_base(ld_base), .ld_words(ld_words),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] model [256];
  logic [15:0] load_words [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_mem(input logic [7:0] addr);
    cpu_rw   = 1'b1;
    cpu_adrs = addr;
    #1;
    check($sformatf("rd_%02h", addr), cpu_din, model[addr]);
  endtask

  task automatic check_all();
    for (int a = 0; a < 256; a++) check_mem(8'(a));
  endtask

  // Streams load_words high byte first; model updated once the load completes.
  task automatic do_load(input logic [7:0] base, input logic [8:0] words,
                         input int stall_pct, input bit toggle, input bit poke,
                         input bit noise);
    int nbytes = 0, ndone = 0, cyc = 0;
    bit clr_high = 0, din_bad = 0;
    cpu_rw   = 1'b1;
    ld_base  = base;
    ld_words = words;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    check("start_ready", ld_ready, 1);
    check("start_cpu_clr", cpu_clr, 0);
    while (nbytes < 2 * int'(words) && cyc < 8000) begin
      ld_valid = toggle ? (cyc % 2 == 1) : ($urandom_range(99) >= stall_pct);
      ld_data  = (nbytes % 2 == 1) ? load_words[nbytes/2][7:0] : load_words[nbytes/2][15:8];
      if (poke) begin
        ld_start = (nbytes == 1);
        ld_base  = base ^ 8'h5A;
        ld_words = 9'd1;
      end
      if (noise) begin
        cpu_rw   = 1'($urandom_range(1));
        cpu_adrs = 8'($urandom);
        cpu_dout = 8'($urandom);
      end
      #1;
      if (cpu_clr) clr_high = 1;
      if (ld_done) ndone++;
      if (cpu_din !== 16'h0) din_bad = 1;
      if (ld_valid && ld_ready) nbytes++;
      step();
      cyc++;
    end
    ld_valid = 1'b0;
    ld_start = 1'b0;
    cpu_rw   = 1'b1;
    check("bytes_accepted", nbytes, 2 * int'(words));
    check("early_done", ndone, 0);
    check("cpu_clr_low_during_load", clr_high, 0);
    check("din_zero_during_load", din_bad, 0);
    check("done_pulse", ld_done, 1);
    check("done_ready", ld_ready, 0);
    check("done_cpu_clr", cpu_clr, 0);
    step();
    check("done_cleared", ld_done, 0);
    check("idle_cpu_clr", cpu_clr, 1);
    for (int i = 0; i < int'(words); i++) model[8'(int'(base) + i)] = load_words[i];
    $display("load base=%02h words=%0d stall=%0d toggle=%0d poke=%0d cycles=%0d",
             base, words, stall_pct, toggle, poke, cyc);
  endtask

  task automatic rand_load(input logic [7:0] base, input logic [8:0] words,
                           input int stall_pct, input bit noise);
    load_words = {};
    for (int i = 0; i < int'(words); i++) load_words.push_back(16'($urandom));
    do_load(base, words, stall_pct, 0, 0, noise);
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data);
    cpu_adrs = addr;
    cpu_dout = data;
    cpu_rw   = 1'b0;
    step();
    cpu_rw = 1'b1;
    model[addr][7:0] = data;
    $display("cpu write adrs=%02h dout=%02h", addr, data);
    check_mem(addr);
  endtask

  initial begin
    logic [7:0] b;
    logic [8:0] w;
    // Reset behaviour
    repeat (3) step();
    check("rst_cpu_clr", cpu_clr, 0);
    check("rst_ready", ld_ready, 0);
    check("rst_done", ld_done, 0);
    clr = 1'b1;
    #1;
    check("rel_cpu_clr_before_edge", cpu_clr, 0);
    step();
    check("rel_cpu_clr", cpu_clr, 1);
    check("rel_ready", ld_ready, 0);

    // Full-array load, base arbitrary: every word written exactly once
    rand_load(8'($urandom), 9'd256, 20, 0);
    check_all();

    // Memory survives reset and is readable during it
    clr = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) check_mem(8'($urandom));
    step();
    clr = 1'b1;
    step();
    check("rst2_cpu_clr", cpu_clr, 1);

    // Directed three-word load
    load_words = '{16'h1234, 16'h5678, 16'h9ABC};
    do_load(8'h10, 9'd3, 0, 0, 0, 0);
    for (int a = 8'h0F; a <= 8'h13; a++) check_mem(8'(a));
    check("dir_mem11", model[8'h11], 16'h5678);

    // Wrap with toggled valid
    load_words = '{16'hC0DE, 16'hBEEF};
    do_load(8'hFF, 9'd2, 0, 1, 0, 0);
    check_mem(8'hFE); check_mem(8'hFF); check_mem(8'h00); check_mem(8'h01);

    // CPU low-byte write
    load_words = '{16'hABCD};
    do_load(8'h20, 9'd1, 0, 0, 0, 0);
    cpu_write(8'h20, 8'h5A);
    check("cpu_wr_const", cpu_din, 16'hAB5A);
    step();
    check_mem(8'h20);

    // Zero-length start ignored
    ld_base  = 8'h30;
    ld_words = 9'd0;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    check("zero_words_ready", ld_ready, 0);
    check("zero_words_cpu_clr", cpu_clr, 1);
    step();
    check("zero_words_ready2", ld_ready, 0);

    // ld_start during LO ignored (would redirect to base^5A otherwise)
    load_words = '{16'h1111, 16'h2222};
    do_load(8'h30, 9'd2, 30, 0, 1, 0);
    check_mem(8'h30); check_mem(8'h31); check_mem(8'h30 ^ 8'h5A);

    // Reset mid-load after three bytes of a four-word load
    b = 8'h40;
    load_words = '{16'hA1A2, model[8'h41] ^ 16'hFFFF, 16'h0F0F, 16'h7777};
    ld_base  = b;
    ld_words = 9'd4;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1'b1;
      ld_data  = (k % 2 == 1) ? load_words[k/2][7:0] : load_words[k/2][15:8];
      step();
    end
    ld_valid = 1'b0;
    clr = 1'b0;
    model[b] = load_words[0];
    #1;
    check("abort_ready", ld_ready, 0);
    check("abort_done", ld_done, 0);
    check("abort_cpu_clr", cpu_clr, 0);
    check_mem(b);
    step(); step();
    check("abort_cpu_clr_held", cpu_clr, 0);
    clr = 1'b1;
    #1;
    check("abort_rel_cpu_clr", cpu_clr, 0);
    step();
    check("abort_idle_cpu_clr", cpu_clr, 1);
    $display("abort load base=%02h after 3 bytes", b);
    for (int a = 0; a < 4; a++) check_mem(8'(int'(b) + a));

    // Random mix of loads (with CPU noise) and CPU writes
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(2) == 0) begin
        cpu_write(8'($urandom), 8'($urandom));
      end else begin
        b = 8'($urandom);
        w = 9'($urandom_range(8, 1));
        rand_load(b, w, $urandom_range(60), 1);
        for (int a = -1; a <= int'(w); a++) check_mem(8'(int'(b) + a));
      end
    end
    check_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
